// File: rtl/lsu_dmem_port_if.sv
// Word-wide req/ack data-memory port between the load/store unit and the data RAM.
interface lsu_dmem_port_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/lsu_dmem_port.sv
// RV32I load/store unit: formats MEM-stage accesses into byte-enabled word requests,
// stalls until ack or timeout, and returns extended load data.
module lsu_dmem_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_m,
  input  logic                  mem_write_m,
  input  logic [2:0]            funct3_m,
  input  logic [31:0]           addr_m,
  input  logic [31:0]           wdata_m,
  output logic                  stall_m,
  output logic [31:0]           rdata_m,
  output logic                  misalign_m,
  output logic                  fault_m,
  lsu_dmem_port_if.master       dm
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_r, state_nx_s;
  logic        req_r, we_r, timeout_r;
  logic [31:0] addr_r, wdata_r, rdata_r;
  logic [3:0]  be_r;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic [7:0]  cnt_r;
  logic        access_s, illegal_s, misalign_s;
  logic        issue_s, ack_s, expire_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;

  function automatic logic [31:0] load_format(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] shifted;
    logic [15:0] half;
    logic [31:0] res;
    shifted = word >> {off, 3'b000};
    half    = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  res = {{16{half[15]}}, half};
      3'b100:  res = {24'd0, shifted[7:0]};
      3'b101:  res = {16'd0, half};
      default: res = word;
    endcase
    return res;
  endfunction

  assign access_s = mem_read_m | mem_write_m;

  // Access classification and lane placement of store data.
  always_comb begin
    illegal_s   = 1'b0;
    misalign_s  = 1'b0;
    be_s        = 4'b0000;
    wdata_s     = wdata_m;
    if (mem_read_m && mem_write_m) begin
      illegal_s = 1'b1;
    end else if (mem_read_m) begin
      case (funct3_m)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_s = 1'b0;
        default:                                illegal_s = 1'b1;
      endcase
    end else if (mem_write_m) begin
      case (funct3_m)
        3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
        default:                illegal_s = 1'b1;
      endcase
    end else begin
      illegal_s = 1'b0;
    end
    case (funct3_m[1:0])
      2'b00: begin
        be_s    = 4'b0001 << addr_m[1:0];
        wdata_s = {4{wdata_m[7:0]}};
      end
      2'b01: begin
        misalign_s = addr_m[0];
        be_s       = 4'b0011 << {addr_m[1], 1'b0};
        wdata_s    = {2{wdata_m[15:0]}};
      end
      default: begin
        misalign_s = (addr_m[1:0] != 2'b00);
        be_s       = 4'b1111;
        wdata_s    = wdata_m;
      end
    endcase
  end

  // Next state and combinational pipeline controls.
  always_comb begin
    state_nx_s = state_r;
    stall_m    = 1'b0;
    misalign_m = 1'b0;
    fault_m    = 1'b0;
    issue_s    = 1'b0;
    ack_s      = 1'b0;
    expire_s   = 1'b0;
    if (!rst) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (!access_s) begin
            state_nx_s = IDLE;
          end else if (illegal_s) begin
            fault_m = 1'b1;
          end else if (misalign_s) begin
            misalign_m = 1'b1;
          end else begin
            stall_m    = 1'b1;
            issue_s    = 1'b1;
            state_nx_s = BUSY;
          end
        end
        BUSY: begin
          stall_m = 1'b1;
          if (dm.dm_ack) begin
            ack_s      = 1'b1;
            state_nx_s = DONE;
          end else if (cnt_r == CNT_LAST) begin
            expire_s   = 1'b1;
            state_nx_s = DONE;
          end else begin
            state_nx_s = BUSY;
          end
        end
        DONE: begin
          fault_m    = timeout_r;
          state_nx_s = IDLE;
        end
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Request latch, wait counter, timeout flag and load result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_r     <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= 32'd0;
      be_r      <= 4'b0000;
      wdata_r   <= 32'd0;
      rdata_r   <= 32'd0;
      f3_r      <= 3'b000;
      off_r     <= 2'b00;
      cnt_r     <= 8'd0;
      timeout_r <= 1'b0;
    end else if (issue_s) begin
      req_r   <= 1'b1;
      we_r    <= mem_write_m;
      addr_r  <= {addr_m[31:2], 2'b00};
      be_r    <= be_s;
      wdata_r <= wdata_s;
      f3_r    <= funct3_m;
      off_r   <= addr_m[1:0];
      cnt_r   <= 8'd0;
    end else if (ack_s) begin
      req_r <= 1'b0;
      if (!we_r) begin
        rdata_r <= load_format(dm.dm_rdata, f3_r, off_r);
      end
    end else if (expire_s) begin
      req_r     <= 1'b0;
      timeout_r <= 1'b1;
      rdata_r   <= 32'd0;
    end else if (state_r == BUSY) begin
      cnt_r <= cnt_r + 8'd1;
    end else if (state_r == DONE) begin
      timeout_r <= 1'b0;
    end
  end

  assign dm.dm_req   = req_r;
  assign dm.dm_we    = we_r;
  assign dm.dm_addr  = addr_r;
  assign dm.dm_be    = be_r;
  assign dm.dm_wdata = wdata_r;
  assign rdata_m     = rdata_r;

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Scoreboard bench for lsu_dmem_port: directed accesses, a scripted memory responder,
// and independent monitors for retirement responses and memory requests.
module tb_lsu_dmem_port;
  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        mem_read_m, mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] addr_m, wdata_m;
  logic        stall_m, misalign_m, fault_m;
  logic [31:0] rdata_m;

  lsu_dmem_port_if dmb ();

  lsu_dmem_port #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read_m (mem_read_m),
    .mem_write_m(mem_write_m),
    .funct3_m   (funct3_m),
    .addr_m     (addr_m),
    .wdata_m    (wdata_m),
    .stall_m    (stall_m),
    .rdata_m    (rdata_m),
    .misalign_m (misalign_m),
    .fault_m    (fault_m),
    .dm         (dmb)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        flt;
    int          stalls;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    int          cycles;
  } req_t;

  resp_t       resp_q[$];
  req_t        req_q[$];
  int          n_tests;
  int          n_fail;
  int          ack_at_v;
  logic [31:0] mem_rdata_v;
  bit          force_ack;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: acks on the ack_at_v-th cycle dm_req is high (0 = never).
  initial begin
    int mcnt;
    mcnt        = 0;
    dmb.dm_ack   = 1'b0;
    dmb.dm_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (dmb.dm_req === 1'b1) mcnt++;
      else mcnt = 0;
      dmb.dm_ack   = ((dmb.dm_req === 1'b1) && (ack_at_v != 0) && (mcnt == ack_at_v)) || force_ack;
      dmb.dm_rdata = mem_rdata_v;
    end
  end

  // Response monitor: an access retires on a cycle where it is present and not stalled.
  initial begin
    int    scnt;
    resp_t e;
    scnt = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        scnt = 0;
      end else if (mem_read_m || mem_write_m) begin
        if (stall_m) begin
          scnt++;
        end else begin
          if (resp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_unexpected: got retirement expected none");
          end else begin
            e = resp_q.pop_front();
            check32("rdata", rdata_m, e.rdata);
            check32("misalign", 32'(misalign_m), 32'(e.mis));
            check32("fault", 32'(fault_m), 32'(e.flt));
            check32("stall_cycles", 32'(scnt), 32'(e.stalls));
          end
          scnt = 0;
        end
      end
    end
  end

  // Request monitor: checks request fields every cycle dm_req is high and its duration.
  initial begin
    bit   inq;
    int   rc;
    req_t e;
    inq = 1'b0;
    rc  = 0;
    forever begin
      @(negedge clk);
      if (dmb.dm_req === 1'b1) begin
        if (!inq) begin
          inq = 1'b1;
          rc  = 0;
          if (req_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_unexpected: got dm_req=1 addr %h expected no request", dmb.dm_addr);
          end
        end
        rc++;
        if (req_q.size() != 0) begin
          e = req_q[0];
          check32("dm_addr", dmb.dm_addr, e.addr);
          check32("dm_be", 32'(dmb.dm_be), 32'(e.be));
          check32("dm_wdata", dmb.dm_wdata, e.wdata);
          check32("dm_we", 32'(dmb.dm_we), 32'(e.we));
        end
      end else if (inq) begin
        inq = 1'b0;
        if (req_q.size() != 0) begin
          e = req_q.pop_front();
          check32("req_cycles", 32'(rc), 32'(e.cycles));
        end
      end
    end
  end

  task automatic drive_idle();
    mem_read_m  = 1'b0;
    mem_write_m = 1'b0;
    funct3_m    = 3'b000;
    addr_m      = 32'd0;
    wdata_m     = 32'd0;
  endtask

  task automatic do_acc(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] mrd,
                        input logic [31:0] exp_rd, input logic emis, input logic eflt,
                        input int estall, input logic has_req,
                        input logic [31:0] eaddr, input logic [3:0] ebe,
                        input logic [31:0] ewd, input int ecyc);
    resp_t r;
    req_t  q;
    bit    done;
    ack_at_v    = ack_at;
    mem_rdata_v = mrd;
    r.rdata  = exp_rd;
    r.mis    = emis;
    r.flt    = eflt;
    r.stalls = estall;
    resp_q.push_back(r);
    if (has_req) begin
      q.addr   = eaddr;
      q.be     = ebe;
      q.wdata  = ewd;
      q.we     = wr;
      q.cycles = ecyc;
      req_q.push_back(q);
    end
    @(posedge clk);
    #1;
    mem_read_m  = rd;
    mem_write_m = wr;
    funct3_m    = f3;
    addr_m      = a;
    wdata_m     = wd;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!stall_m) begin
        done = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL retire_bound: got no retirement within 50 cycles expected retirement");
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    ack_at_v    = 0;
    mem_rdata_v = 32'd0;
    force_ack   = 1'b0;

    // Reset with a conflicting access present: outputs must stay quiet.
    rst         = 1'b0;
    mem_read_m  = 1'b1;
    mem_write_m = 1'b1;
    funct3_m    = 3'b010;
    addr_m      = 32'h0000_0100;
    wdata_m     = 32'h1111_1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_stall", 32'(stall_m), 32'd0);
    check32("rst_fault", 32'(fault_m), 32'd0);
    check32("rst_misalign", 32'(misalign_m), 32'd0);
    check32("rst_req", 32'(dmb.dm_req), 32'd0);
    check32("rst_we", 32'(dmb.dm_we), 32'd0);
    check32("rst_addr", dmb.dm_addr, 32'd0);
    check32("rst_be", 32'(dmb.dm_be), 32'd0);
    check32("rst_wdata", dmb.dm_wdata, 32'd0);
    check32("rst_rdata", rdata_m, 32'd0);
    @(posedge clk);
    #1;
    drive_idle();
    rst = 1'b1;

    // Loads
    do_acc(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 2, 1'b1, 32'h0000_0100, 4'b1111, 32'd0, 1);
    do_acc(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 1, 32'h8012_3456, 32'hFFFF_FF80, 1'b0, 1'b0, 2, 1'b1, 32'h0000_0100, 4'b1000, 32'd0, 1);
    do_acc(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'd0, 1, 32'h8012_3456, 32'h0000_0080, 1'b0, 1'b0, 2, 1'b1, 32'h0000_0100, 4'b1000, 32'd0, 1);
    do_acc(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'd0, 1, 32'h8012_3456, 32'h0000_8012, 1'b0, 1'b0, 2, 1'b1, 32'h0000_0100, 4'b1100, 32'd0, 1);
    do_acc(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'd0, 2, 32'h8012_3456, 32'hFFFF_8012, 1'b0, 1'b0, 3, 1'b1, 32'h0000_0100, 4'b1100, 32'd0, 2);
    do_acc(1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'd0, 1, 32'h8012_3456, 32'h0000_0034, 1'b0, 1'b0, 2, 1'b1, 32'h0000_0100, 4'b0010, 32'd0, 1);
    do_acc(1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'd0, 1, 32'h1234_F00D, 32'hFFFF_F00D, 1'b0, 1'b0, 2, 1'b1, 32'h0000_0100, 4'b0011, 32'd0, 1);

    // Stores leave rdata_m untouched.
    do_acc(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 3, 32'h5555_5555, 32'hFFFF_F00D, 1'b0, 1'b0, 4, 1'b1, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 3);
    do_acc(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 1, 32'h5555_5555, 32'hFFFF_F00D, 1'b0, 1'b0, 2, 1'b1, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 1);
    do_acc(1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 2, 32'h5555_5555, 32'hFFFF_F00D, 1'b0, 1'b0, 3, 1'b1, 32'h0000_0400, 4'b1111, 32'hCAFE_F00D, 2);

    // Misaligned and illegal accesses: zero stall, no request.
    do_acc(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'd0, 1, 32'h5555_5555, 32'hFFFF_F00D, 1'b1, 1'b0, 0, 1'b0, 32'd0, 4'b0000, 32'd0, 0);
    do_acc(1'b0, 1'b1, 3'b001, 32'h0000_0201, 32'd7, 1, 32'h5555_5555, 32'hFFFF_F00D, 1'b1, 1'b0, 0, 1'b0, 32'd0, 4'b0000, 32'd0, 0);
    do_acc(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'd0, 1, 32'h5555_5555, 32'hFFFF_F00D, 1'b0, 1'b1, 0, 1'b0, 32'd0, 4'b0000, 32'd0, 0);
    do_acc(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'd0, 1, 32'h5555_5555, 32'hFFFF_F00D, 1'b0, 1'b1, 0, 1'b0, 32'd0, 4'b0000, 32'd0, 0);
    do_acc(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'd0, 1, 32'h5555_5555, 32'hFFFF_F00D, 1'b0, 1'b1, 0, 1'b0, 32'd0, 4'b0000, 32'd0, 0);
    do_acc(1'b0, 1'b1, 3'b101, 32'h0000_0101, 32'd0, 1, 32'h5555_5555, 32'hFFFF_F00D, 1'b0, 1'b1, 0, 1'b0, 32'd0, 4'b0000, 32'd0, 0);

    // Timeout: no ack for TO request cycles.
    do_acc(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0, 0, 32'h5555_5555, 32'd0, 1'b0, 1'b1, TO + 1, 1'b1, 32'h0000_0500, 4'b1111, 32'd0, TO);
    @(posedge clk);
    #1;
    drive_idle();
    mem_rdata_v = 32'hFFFF_FFFF;
    force_ack   = 1'b1;
    @(negedge clk);
    check32("late_ack_req", 32'(dmb.dm_req), 32'd0);
    check32("late_ack_stall", 32'(stall_m), 32'd0);
    check32("late_ack_fault", 32'(fault_m), 32'd0);
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    @(negedge clk);
    check32("late_ack_rdata", rdata_m, 32'd0);
    check32("late_ack_req2", 32'(dmb.dm_req), 32'd0);

    // Ack on the last allowed cycle wins over the timeout.
    do_acc(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'd0, TO, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 1'b0, TO + 1, 1'b1, 32'h0000_0600, 4'b1111, 32'd0, TO);

    // Reset asserted in the second BUSY cycle abandons the access.
    begin
      req_t q;
      ack_at_v = 0;
      q.addr   = 32'h0000_0800;
      q.be     = 4'b1111;
      q.wdata  = 32'd0;
      q.we     = 1'b0;
      q.cycles = 2;
      req_q.push_back(q);
    end
    @(posedge clk);
    #1;
    mem_read_m = 1'b1;
    funct3_m   = 3'b010;
    addr_m     = 32'h0000_0800;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check32("busy_rst_stall", 32'(stall_m), 32'd0);
    check32("busy_rst_fault", 32'(fault_m), 32'd0);
    @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
    check32("after_rst_req", 32'(dmb.dm_req), 32'd0);
    check32("after_rst_stall", 32'(stall_m), 32'd0);
    check32("after_rst_addr", dmb.dm_addr, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    do_acc(1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'd0, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b0, 2, 1'b1, 32'h0000_0700, 4'b1111, 32'd0, 1);

    @(posedge clk);
    #1;
    drive_idle();
    repeat (3) @(negedge clk);
    check32("resp_q_empty", 32'(resp_q.size()), 32'd0);
    check32("req_q_empty", 32'(req_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
